// File: rtl/mul_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mul_arbiter_pkg
// Brief   : Shared sizing and operand-packing helpers for the multiplier
//           arbiter and for pipeline blocks that drive it.
// Revision: 1.0
// ============================================================================
package mul_arbiter_pkg;

    // Tag width never collapses to zero, even for a single client.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB position of client k's operand inside a flat packed bus.
    function automatic int slice_base(input int k, input int w);
        return k * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_pipe.sv
`default_nettype none
// ============================================================================
// Module  : mul_pipe
// Brief   : Registered signed multiplier with a matching valid/tag shift line:
//           operand register followed by LATENCY product stages.
// Revision: 1.0
// ============================================================================
module mul_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 1,
    parameter int LATENCY    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    input  logic signed [DATA_WIDTH-1:0]  in_a,
    input  logic signed [DATA_WIDTH-1:0]  in_b,
    output logic                          out_valid,
    output logic [TAG_WIDTH-1:0]          out_tag,
    output logic signed [2*DATA_WIDTH-1:0] out_p
);

    logic                          op_valid_q, op_valid_d;
    logic [TAG_WIDTH-1:0]          op_tag_q, op_tag_d;
    logic signed [DATA_WIDTH-1:0]  op_a_q, op_a_d;
    logic signed [DATA_WIDTH-1:0]  op_b_q, op_b_d;

    logic [LATENCY-1:0]            vld_q, vld_d;
    logic [TAG_WIDTH-1:0]          tag_q  [LATENCY];
    logic [TAG_WIDTH-1:0]          tag_d  [LATENCY];
    logic signed [2*DATA_WIDTH-1:0] prod_q [LATENCY];
    logic signed [2*DATA_WIDTH-1:0] prod_d [LATENCY];

    logic signed [2*DATA_WIDTH-1:0] a_ext, b_ext;

    // Sign-extend before multiplying so the full-precision product is kept.
    assign a_ext = {{DATA_WIDTH{op_a_q[DATA_WIDTH-1]}}, op_a_q};
    assign b_ext = {{DATA_WIDTH{op_b_q[DATA_WIDTH-1]}}, op_b_q};

    always_comb begin
        op_valid_d = in_valid;
        op_tag_d   = in_tag;
        op_a_d     = in_a;
        op_b_d     = in_b;
        vld_d      = '0;
        vld_d[0]   = op_valid_q;
        tag_d[0]   = op_tag_q;
        prod_d[0]  = a_ext * b_ext;
        for (int s = 1; s < LATENCY; s++) begin
            vld_d[s]  = vld_q[s-1];
            tag_d[s]  = tag_q[s-1];
            prod_d[s] = prod_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_valid_q <= 1'b0;
            vld_q      <= '0;
        end else begin
            op_valid_q <= op_valid_d;
            vld_q      <= vld_d;
        end
    end

    // Datapath registers carry no reset; only the valid line gates them.
    always_ff @(posedge clk) begin
        op_tag_q <= op_tag_d;
        op_a_q   <= op_a_d;
        op_b_q   <= op_b_d;
        for (int s = 0; s < LATENCY; s++) begin
            tag_q[s]  <= tag_d[s];
            prod_q[s] <= prod_d[s];
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];
    assign out_p     = prod_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mul_arbiter
// Brief   : Round-robin request/grant arbiter sharing one pipelined signed
//           multiplier; results return tagged to the issuing client.
// Revision: 1.0
// ============================================================================
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int N_CLIENTS   = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int MUL_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_CLIENTS-1:0]            req,
    input  logic [N_CLIENTS*DATA_WIDTH-1:0] a_flat,
    input  logic [N_CLIENTS*DATA_WIDTH-1:0] b_flat,
    output logic [N_CLIENTS-1:0]            grant,
    output logic [2*DATA_WIDTH-1:0]         result,
    output logic [N_CLIENTS-1:0]            done,
    output logic                            busy
);

    localparam int c_tag_w = tag_width(N_CLIENTS);

    logic [c_tag_w-1:0]             ptr_q, ptr_d;
    logic [N_CLIENTS-1:0]           outstanding_q, outstanding_d;
    logic [N_CLIENTS-1:0]           grant_q, grant_d;
    logic [N_CLIENTS-1:0]           done_q, done_d;
    logic [2*DATA_WIDTH-1:0]        result_q, result_d;

    logic [N_CLIENTS-1:0]           eligible;
    logic                           found;
    logic [c_tag_w-1:0]             sel;
    int                             idx;
    logic signed [DATA_WIDTH-1:0]   sel_a, sel_b;

    logic                           pipe_valid;
    logic [c_tag_w-1:0]             pipe_tag;
    logic signed [2*DATA_WIDTH-1:0] pipe_p;

    // A client with a product in flight is masked, so a held req never double-issues.
    assign eligible = req & ~outstanding_q;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_CLIENTS) begin
                idx = idx - N_CLIENTS;
            end
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = c_tag_w'(idx);
            end
        end
    end

    assign sel_a = a_flat[slice_base(int'(sel), DATA_WIDTH) +: DATA_WIDTH];
    assign sel_b = b_flat[slice_base(int'(sel), DATA_WIDTH) +: DATA_WIDTH];

    mul_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (c_tag_w),
        .LATENCY    (MUL_LATENCY)
    ) u_mul_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (found),
        .in_tag    (sel),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .out_p     (pipe_p)
    );

    always_comb begin
        ptr_d         = ptr_q;
        outstanding_d = outstanding_q;
        grant_d       = '0;
        done_d        = '0;
        result_d      = result_q;
        if (pipe_valid) begin
            outstanding_d[pipe_tag] = 1'b0;
            done_d[pipe_tag]        = 1'b1;
            result_d                = pipe_p;
        end
        if (found) begin
            outstanding_d[sel] = 1'b1;
            grant_d[sel]       = 1'b1;
            if (int'(sel) == N_CLIENTS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q         <= '0;
            outstanding_q <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            result_q      <= '0;
        end else begin
            ptr_q         <= ptr_d;
            outstanding_q <= outstanding_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            result_q      <= result_d;
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign result = result_q;
    assign busy   = |outstanding_q;

endmodule
`default_nettype wire

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Request/grant arbiter sharing one pipelined signed multiplier among the pipeline blocks.
- Replaces fixed time-slot multiplier sharing, so a block waits only when another block is actually contending.
- Sits in pipeline beside the LUT and delay arbiters, with one client port per pipeline_block.
- Fair round-robin issue, at most one product accepted per cycle; results return tagged to the originating client in issue order.

Parameters:
- n_clients, 2: number of requesting blocks; must be ≥1.
- data_width, 16: operand width; operands are signed two's complement.
- mul_latency, 2: multiplier pipeline stages from issue to result; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low; 0 = reset.
- req  in  n_clients  per-client request level.
- a_flat  in  n_clients*data_width  operand A, client k at [k*data_width +: data_width].
- b_flat  in  n_clients*data_width  operand B, same packing.
- grant  out  n_clients  one-hot pulse: the request was accepted.
- result  out  2*data_width  signed full-precision product.
- done  out  n_clients  one-hot pulse: result is valid for that client.
- busy  out  1  high while any product is in flight.

Behaviour:
- Reset (reset==0 at a clk edge):
  - grant=0, done=0, result=0, busy=0.
  - Outstanding mask cleared; pipeline valid bits cleared.
  - Round-robin pointer set so client 0 has highest priority.
  - In-flight products are discarded; no done is ever emitted for them.
- Eligibility: client k is eligible when req[k]=1 and outstanding[k]=0.
- Selection:
  - Each cycle, choose the first eligible client scanning k = ptr, ptr+1, … modulo n_clients.
  - ptr = index of the last granted client + 1, wrapping from n_clients-1 to 0.
- Issue, on the edge where client k is selected:
  - A_k and B_k are captured into stage 1 with tag k and valid=1.
  - outstanding[k] is set; ptr advances.
  - grant[k] is high for exactly the following cycle.
- No eligible client: stage 1 gets valid=0; ptr is unchanged.
- Client contract:
  - Hold req and operands stable until grant is seen; drop or change them afterwards.
  - req still high during the grant cycle is masked by outstanding and is never double-issued.
- Latency:
  - Product is computed as the full 2*data_width signed product; no rounding or saturation.
  - It exits stage mul_latency, then drives result and done[tag] one clk later.
  - Issue edge to done pulse: mul_latency+1 cycles. Example: mul_latency=2 → req sampled at edge N, grant during N..N+1, done during N+3..N+4.
- Completion:
  - On the done edge, outstanding[tag] is cleared.
  - The client may be re-selected in the same cycle that done is high; the earliest re-issue is the edge after the done edge.
- Throughput:
  - 1 issue per cycle aggregate; 1 per mul_latency+2 cycles per client.
  - Results retire in issue order; done is one-hot or zero.
- Holding: result keeps its last value between done pulses.
- busy = OR of all outstanding bits.
- Edge cases:
  - Extreme operands: -2^(dw-1) × -2^(dw-1) = +2^(2dw-2), which fits in the output without overflow.
  - n_clients=1: pointer logic degenerates, and issue occurs every mul_latency+2 cycles under constant req.
  - Simultaneous requests from all clients are served in strict rotation.

Decomposition:
- Shared header mul_arb.vh:
  - MUL_TAG_WIDTH macro, $clog2(n_clients) with a minimum of 1.
  - Packing helper macros for the operand slices, reusable by pipeline_block.
- Sub-module mul_pipe (params data_width, tag_width, latency):
  - Registered signed multiply with a valid/tag shift line.
  - Keeps the DSP inference isolated from the arbitration logic.
- The arbiter itself holds only the pointer, the outstanding mask, selection and output registers.

Test Plan:
- Reset: hold reset=0 with req=all ones → grant=0, done=0, result=0, busy=0 throughout; after release, first grant goes to client 0.
- Single request: client 1 asserts req with A=300, B=-7 (mul_latency=2) → grant[1] pulse one cycle after sampling; done[1] 3 cycles after the issue edge with result=-2100; busy high in between.
- Full contention: n_clients=4, all req held high → grants in order 0,1,2,3,0…; each client is re-granted only after its own done; results match per-client operands.
- Extremes: A=B=-32768 (dw=16) → result=1073741824. A=32767, B=-32768 → -1073709056.
- Mid-operation reset: pull reset low with 2 products in flight → no done pulses, busy=0, outstanding cleared; a fresh request after release completes normally.
- Stale req: a client keeps req high through its grant cycle with unchanged operands → exactly one issue until its done, then a second issue.
